// File: rtl/ex_mem.sv
// ex_mem -- EX/MEM pipeline register.
//
// Captures the EX-stage results on each rising clk edge. It honours the
// pipeline stall vector and flush, and counts the bubbles it inserts.
// The registered HI/LO outputs also serve as forwarding sources for EX.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   stall[5:0] stall vector; only bit3 (EX) and bit4 (MEM) are used
//   flush      synchronous flush; kills the instruction entering MEM
//   ex_*       EX-stage results: wd/wreg/wdata and hi/lo/whilo
//   mem_*      registered copies of ex_*, plus mem_valid (0 = bubble)
//   bubble_cnt wrapping count of EX-stall bubbles since reset
module ex_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic              ex_whilo,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_whilo,
  output logic              mem_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                whilo_q, whilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Stall bits for the other stages have no effect on this register.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    cnt_d   = cnt_q;

    if (flush) begin
      state_d = EMPTY;
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
    end else if (stall[3] && !stall[4]) begin
      // EX is stalled but MEM is advancing. Insert a bubble so that a
      // multi-cycle op cannot be issued more than once, and so that no
      // partial result reaches MEM.
      state_d = EMPTY;
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (stall[4]) begin
      // MEM is stalled: hold everything. This also covers the
      // stall[3]=0 / stall[4]=1 combination, which must never capture.
      state_d = state_q;
    end else begin
      state_d = FULL;
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd     = wd_q;
  assign mem_wreg   = wreg_q;
  assign mem_wdata  = wdata_q;
  assign mem_hi     = hi_q;
  assign mem_lo     = lo_q;
  assign mem_whilo  = whilo_q;
  assign mem_valid  = (state_q == FULL);
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo, mem_valid;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the expected contents of the EX/MEM register.
  logic [4:0]  e_wd;
  logic        e_wreg;
  logic [31:0] e_wdata, e_hi, e_lo;
  logic        e_whilo, e_valid;
  logic [15:0] e_cnt;

  always #5 clk = ~clk;

  ex_mem #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_valid(mem_valid), .bubble_cnt(bubble_cnt)
  );

  task automatic model_clear();
    e_wd = '0; e_wreg = 1'b0; e_wdata = '0; e_hi = '0; e_lo = '0;
    e_whilo = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    e_cnt = '0;
  endtask

  // One clock edge of the register, applied in the documented priority order.
  task automatic model_edge();
    if (flush) begin
      model_clear();
    end else if (stall[3] && !stall[4]) begin
      model_clear();
      e_cnt = 16'((32'(e_cnt) + 1) % 65536);
    end else if (stall[4]) begin
      // hold
    end else begin
      e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
      e_hi = ex_hi; e_lo = ex_lo; e_whilo = ex_whilo; e_valid = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wd"},    64'(mem_wd),     64'(e_wd));
    chk({tag, ".wreg"},  64'(mem_wreg),   64'(e_wreg));
    chk({tag, ".wdata"}, 64'(mem_wdata),  64'(e_wdata));
    chk({tag, ".hi"},    64'(mem_hi),     64'(e_hi));
    chk({tag, ".lo"},    64'(mem_lo),     64'(e_lo));
    chk({tag, ".whilo"}, 64'(mem_whilo),  64'(e_whilo));
    chk({tag, ".valid"}, 64'(mem_valid),  64'(e_valid));
    chk({tag, ".cnt"},   64'(bubble_cnt), 64'(e_cnt));
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
  endtask

  // Drive control, take one edge, update the model, then sample 1 time unit later.
  task automatic step(input logic [5:0] s, input logic f, input string tag);
    stall = s; flush = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    set_ex('0, 1'b0, '0, '0, '0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b1;

    // 1: basic capture
    set_ex(5'd5, 1'b1, 32'h1234_5678, '0, '0, 1'b0);
    step(6'b000000, 1'b0, "t1_capture");
    chk("t1_lit_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("t1_lit_valid", 64'(mem_valid), 64'd1);

    // 2: HI/LO capture, then EX stalled for 3 edges (DIV busy)
    set_ex(5'd0, 1'b0, '0, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
    step(6'b000000, 1'b0, "t2_hilo");
    chk("t2_lit_hi", 64'(mem_hi), 64'hAAAA_0000);
    set_ex(5'd7, 1'b1, 32'h5, 32'h1, 32'h2, 1'b1);
    step(6'b001111, 1'b0, "t2_bub1");
    chk("t2_lit_whilo", 64'(mem_whilo), 64'd0);
    step(6'b001111, 1'b0, "t2_bub2");
    step(6'b001111, 1'b0, "t2_bub3");
    chk("t2_lit_cnt", 64'(bubble_cnt), 64'd3);

    // Stall bits outside EX/MEM do not affect capture.
    set_ex(5'd9, 1'b1, 32'h9999, 32'h0, 32'h0, 1'b0);
    step(6'b100111, 1'b0, "t2_ignored_bits");

    // 3: MEM stalled while FULL holds the register
    set_ex(5'd3, 1'b1, 32'hDEAD_BEEF, '0, '0, 1'b0);
    step(6'b000000, 1'b0, "t3_fill");
    set_ex(5'd4, 1'b0, 32'h1, '0, '0, 1'b0);
    step(6'b011111, 1'b0, "t3_hold1");
    step(6'b011111, 1'b0, "t3_hold2");
    chk("t3_lit_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    // The stall[3]=0 / stall[4]=1 combination also holds.
    step(6'b010000, 1'b0, "t3_hold_odd");

    // 4: flush wins over EX stall, no count
    step(6'b001111, 1'b1, "t4_flush");
    chk("t4_lit_valid", 64'(mem_valid), 64'd0);
    chk("t4_lit_cnt", 64'(bubble_cnt), 64'd3);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      set_ex(5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
      s = 6'($urandom);
      case ($urandom_range(0, 3))
        0: s[4:3] = 2'b00;
        1: s[4:3] = 2'b01;
        2: s[4:3] = 2'b11;
        default: s[4:3] = 2'b10;
      endcase
      step(s, ($urandom_range(0, 9) == 0), "rand");
    end

    // 5: counter wrap
    while (e_cnt != 16'hFFFF) step(6'b001000, 1'b0, "t5_fill");
    chk("t5_lit_max", 64'(bubble_cnt), 64'hFFFF);
    step(6'b001000, 1'b0, "t5_wrap");
    chk("t5_lit_wrap", 64'(bubble_cnt), 64'h0);

    // 6: asynchronous reset mid-cycle while FULL and held
    set_ex(5'd11, 1'b1, 32'hCAFE_F00D, 32'h11, 32'h22, 1'b1);
    step(6'b000000, 1'b0, "t6_fill");
    step(6'b010000, 1'b0, "t6_hold");
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_lit_valid", 64'(mem_valid), 64'd0);
    @(negedge clk); rst = 1'b1;
    set_ex(5'd21, 1'b1, 32'h0BAD_F00D, 32'h33, 32'h44, 1'b0);
    step(6'b000000, 1'b0, "t6_fresh");
    chk("t6_lit_wd", 64'(mem_wd), 64'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
